// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file (one write port, two combinational
// read ports) with a per-register busy scoreboard for outstanding multicycle
// writebacks and a registered count of busy registers.
// Optional feature macro: REGFILE_BYPASS_EN enables the same-cycle
// write-to-read bypass on both read ports (data and busy flags).
module regfile_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  input  logic                  ctrl_markBusy,
  input  logic [ADDR_WIDTH-1:0] ctrl_busyReg,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  output logic                  busy_A,
  output logic                  busy_B,
  output logic [ADDR_WIDTH:0]   busy_count
);

  localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W    = ADDR_WIDTH + 1;
  localparam bit          HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;

  logic wr_ok_c;
  logic mark_ok_c;
  logic inc_c;
  logic dec_c;

  // Qualify write/mark strobes: register 0 is untouchable when hardwired.
  always_comb begin
    wr_ok_c   = ctrl_writeEnable && !(HAS_ZERO && (ctrl_writeReg == '0));
    mark_ok_c = ctrl_markBusy    && !(HAS_ZERO && (ctrl_busyReg  == '0));
  end

  // Next state: data write, busy clear on write, busy set on mark (mark wins).
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok_c) begin
      regs_d[ctrl_writeReg] = data_writeReg;
      busy_d[ctrl_writeReg] = 1'b0;
    end
    if (mark_ok_c) begin
      busy_d[ctrl_busyReg] = 1'b1;
    end
  end

  // Counter tracks popcount(busy) incrementally: +1 on a fresh mark, -1 when a
  // write retires a busy register that is not being re-marked in the same cycle.
  always_comb begin
    inc_c   = mark_ok_c && !busy_q[ctrl_busyReg];
    dec_c   = wr_ok_c && busy_q[ctrl_writeReg]
              && !(mark_ok_c && (ctrl_busyReg == ctrl_writeReg));
    count_d = count_q + CNT_W'(inc_c) - CNT_W'(dec_c);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // Combinational read port A (stored value, optionally bypassed).
  always_comb begin
    data_readRegA = (HAS_ZERO && (ctrl_readRegA == '0)) ? '0 : regs_q[ctrl_readRegA];
    busy_A        = busy_q[ctrl_readRegA];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok_c && (ctrl_writeReg == ctrl_readRegA)) begin
      data_readRegA = data_writeReg;
      busy_A        = mark_ok_c && (ctrl_busyReg == ctrl_readRegA);
    end
`endif
  end

  // Combinational read port B (stored value, optionally bypassed).
  always_comb begin
    data_readRegB = (HAS_ZERO && (ctrl_readRegB == '0)) ? '0 : regs_q[ctrl_readRegB];
    busy_B        = busy_q[ctrl_readRegB];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok_c && (ctrl_writeReg == ctrl_readRegB)) begin
      data_readRegB = data_writeReg;
      busy_B        = mark_ok_c && (ctrl_busyReg == ctrl_readRegB);
    end
`endif
  end

  // Busy count is the registered counter itself.
  always_comb begin
    busy_count = count_q;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed, table-driven bench for regfile_sb (default parameters).
// Each vector drives inputs after the falling edge, checks outputs 1 ns later
// (before the rising edge that commits the vector), then the edge happens.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock;
  logic        ctrl_reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic        ctrl_markBusy;
  logic [4:0]  ctrl_busyReg;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic        busy_A;
  logic        busy_B;
  logic [5:0]  busy_count;

  regfile_sb dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .ctrl_markBusy    (ctrl_markBusy),
    .ctrl_busyReg     (ctrl_busyReg),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB),
    .busy_A           (busy_A),
    .busy_B           (busy_B),
    .busy_count       (busy_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        mk;
    logic [4:0]  br;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        ba;
    logic        bb;
    logic [5:0]  ec;
  } vec_t;

  vec_t tv[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic rst, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb,
                       input logic mk, input logic [4:0] br);
    ctrl_reset       = rst;
    ctrl_writeEnable = we;
    ctrl_writeReg    = wr;
    data_writeReg    = wd;
    ctrl_readRegA    = ra;
    ctrl_readRegB    = rb;
    ctrl_markBusy    = mk;
    ctrl_busyReg     = br;
  endtask

  logic [31:0] model_busy;

  initial begin
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
    repeat (2) @(posedge clock);

    // rst we wr wd ra rb mk br | ea eb ba bb cnt
    tv.push_back('{1'b0,1'b1,5'd5,32'hDEADBEEF,5'd1,5'd0,1'b0,5'd0, 32'h0,32'h0,1'b0,1'b0,6'd0});
    tv.push_back('{1'b1,1'b1,5'd6,32'h00001111,5'd5,5'd7,1'b1,5'd5, 32'hDEADBEEF,32'h0,1'b0,1'b0,6'd0});
    tv.push_back('{1'b0,1'b0,5'd0,32'h0,5'd5,5'd6,1'b0,5'd0, 32'h0,32'h0,1'b0,1'b0,6'd0});
    tv.push_back('{1'b0,1'b1,5'd3,32'h12345678,5'd1,5'd2,1'b0,5'd0, 32'h0,32'h0,1'b0,1'b0,6'd0});
    tv.push_back('{1'b0,1'b1,5'd0,32'hFFFFFFFF,5'd3,5'd3,1'b0,5'd0, 32'h12345678,32'h12345678,1'b0,1'b0,6'd0});
    tv.push_back('{1'b0,1'b0,5'd0,32'h0,5'd0,5'd0,1'b1,5'd7, 32'h0,32'h0,1'b0,1'b0,6'd0});
    tv.push_back('{1'b0,1'b0,5'd0,32'h0,5'd7,5'd9,1'b1,5'd9, 32'h0,32'h0,1'b1,1'b0,6'd1});
    tv.push_back('{1'b0,1'b1,5'd7,32'h0000000A,5'd7,5'd9,1'b0,5'd0,
                   (BYP ? 32'hA : 32'h0),32'h0,(BYP ? 1'b0 : 1'b1),1'b1,6'd2});
    tv.push_back('{1'b0,1'b0,5'd0,32'h0,5'd7,5'd9,1'b0,5'd0, 32'hA,32'h0,1'b0,1'b1,6'd1});
    tv.push_back('{1'b0,1'b1,5'd4,32'h00000055,5'd1,5'd4,1'b1,5'd4,
                   32'h0,(BYP ? 32'h55 : 32'h0),1'b0,(BYP ? 1'b1 : 1'b0),6'd1});
    tv.push_back('{1'b0,1'b0,5'd0,32'h0,5'd4,5'd4,1'b0,5'd0, 32'h55,32'h55,1'b1,1'b1,6'd2});
    tv.push_back('{1'b0,1'b1,5'd4,32'h00000066,5'd9,5'd1,1'b0,5'd0, 32'h0,32'h0,1'b1,1'b0,6'd2});
    tv.push_back('{1'b0,1'b1,5'd3,32'h00000077,5'd4,5'd9,1'b1,5'd9, 32'h66,32'h0,1'b0,1'b1,6'd1});
    tv.push_back('{1'b0,1'b0,5'd0,32'h0,5'd3,5'd9,1'b0,5'd0, 32'h77,32'h0,1'b0,1'b1,6'd1});
    tv.push_back('{1'b0,1'b1,5'd6,32'h0000CAFE,5'd6,5'd3,1'b0,5'd0,
                   (BYP ? 32'hCAFE : 32'h0),32'h77,1'b0,1'b0,6'd1});
    tv.push_back('{1'b0,1'b1,5'd9,32'h0,5'd6,5'd6,1'b0,5'd0, 32'hCAFE,32'hCAFE,1'b0,1'b0,6'd1});
    tv.push_back('{1'b0,1'b1,5'd10,32'h000000BB,5'd9,5'd0,1'b1,5'd11, 32'h0,32'h0,1'b0,1'b0,6'd0});
    tv.push_back('{1'b0,1'b0,5'd0,32'h0,5'd10,5'd11,1'b0,5'd0, 32'hBB,32'h0,1'b0,1'b1,6'd1});

    foreach (tv[k]) begin
      @(negedge clock);
      drive(tv[k].rst, tv[k].we, tv[k].wr, tv[k].wd, tv[k].ra, tv[k].rb, tv[k].mk, tv[k].br);
      #1;
      check($sformatf("v%0d rdA", k), data_readRegA, tv[k].ea);
      check($sformatf("v%0d rdB", k), data_readRegB, tv[k].eb);
      check($sformatf("v%0d busyA", k), 32'(busy_A), 32'(tv[k].ba));
      check($sformatf("v%0d busyB", k), 32'(busy_B), 32'(tv[k].bb));
      check($sformatf("v%0d count", k), 32'(busy_count), 32'(tv[k].ec));
    end

    // Fill the scoreboard: mark r1..r31 (r11 already busy), then r0.
    model_busy = 32'h0000_0800;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clock);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i - 1), 5'd0, 1'b1, 5'(i % 32));
      #1;
      check($sformatf("fill%0d count", i), 32'(busy_count), 32'($countones(model_busy)));
      if (i > 1) check($sformatf("fill%0d busyA", i), 32'(busy_A), 32'h1);
      @(posedge clock);
      if (i < 32) model_busy[i] = 1'b1;
    end
    @(negedge clock);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
    #1;
    check("full count", 32'(busy_count), 32'd31);
    check("r0 never busy", 32'(busy_A), 32'h0);

    // Drain: write every register back, then write an idle register.
    for (int i = 1; i <= 32; i++) begin
      @(negedge clock);
      drive(1'b0, 1'b1, 5'(i % 32 == 0 ? 1 : i), 32'(i * 3), 5'd0, 5'd0, 1'b0, 5'd0);
      #1;
      check($sformatf("drain%0d count", i), 32'(busy_count), 32'($countones(model_busy)));
      @(posedge clock);
      if (i < 32) model_busy[i] = 1'b0;
    end
    @(negedge clock);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd31, 1'b0, 5'd0);
    #1;
    check("empty count", 32'(busy_count), 32'd0);
    check("r2 value", data_readRegA, 32'd6);
    check("r31 value", data_readRegB, 32'd93);
    check("r2 idle", 32'(busy_A), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
